// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int baud_div(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and pulses tick on the last count; held at 0 while clear.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clear || count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == CW'(DIV - 1));

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB-first, optional parity, 1-2 stop bits).
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 txValid,
    input  logic [DATA_BITS-1:0] txIn,
    output logic                 txReady,
    output logic                 tx,
    output logic                 busy,
    output logic                 txDone
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W = ($clog2(DATA_BITS) < 2) ? 2 : $clog2(DATA_BITS);

    if (DIV < 2) begin : gDivChk
        $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gDataChk
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gStopChk
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : gParChk
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end

    uart_tx_state_e       state, stateNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic [IDX_W-1:0]     bitIdx, bitNext;
    logic                 txNext, doneNext, tick;

    uart_baud_gen #(.DIV(DIV)) uBaud (
        .clk   (clk),
        .rstN  (rstN),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY != PAR_NONE);
    logic parBit;

    // Parity is fixed at handshake time so it matches the latched character.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            parBit <= 1'b0;
        end else if (state == ST_IDLE && txValid) begin
            parBit <= (PARITY == PAR_EVEN) ? ^txIn : ~^txIn;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            bitIdx   <= '0;
            tx       <= 1'b1;
            txDone   <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftNext;
            bitIdx   <= bitNext;
            tx       <= txNext;
            txDone   <= doneNext;
        end
    end

    // tx is loaded with the value of the bit being entered, so it changes on the transition edge.
    always_comb begin
        stateNext = state;
        shiftNext = shiftReg;
        bitNext   = bitIdx;
        txNext    = tx;
        doneNext  = 1'b0;
        case (state)
            ST_IDLE: begin
                txNext = 1'b1;
                if (txValid) begin
                    stateNext = ST_START;
                    shiftNext = txIn;
                    bitNext   = '0;
                    txNext    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    stateNext = ST_DATA;
                    txNext    = shiftReg[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bitIdx == IDX_W'(DATA_BITS - 1)) begin
                        bitNext = '0;
`ifdef UART_TX_PARITY_EN
                        if (PAR_ON) begin
                            stateNext = ST_PARITY;
                            txNext    = parBit;
                        end else begin
                            stateNext = ST_STOP;
                            txNext    = 1'b1;
                        end
`else
                        stateNext = ST_STOP;
                        txNext    = 1'b1;
`endif
                    end else begin
                        shiftNext = shiftReg >> 1;
                        bitNext   = bitIdx + 1'b1;
                        txNext    = shiftReg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    stateNext = ST_STOP;
                    txNext    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                txNext = 1'b1;
                if (tick) begin
                    if (bitIdx == IDX_W'(STOP_BITS - 1)) begin
                        stateNext = ST_IDLE;
                        bitNext   = '0;
                        doneNext  = 1'b1;
                    end else begin
                        bitNext = bitIdx + 1'b1;
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

    assign txReady = (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 5N2) against a frame-level model.
module tb_uart_tx_param;

    localparam int DIV = 10;
    localparam int NU  = 4;
    localparam int CFG_DB [NU] = '{8, 8, 8, 5};
    localparam int CFG_PAR[NU] = '{0, 2, 1, 0};
    localparam int CFG_SB [NU] = '{1, 1, 1, 2};

    logic       clk;
    logic       rstN;
    logic       vld  [NU];
    logic [8:0] din  [NU];
    logic       rdyS [NU];
    logic       txS  [NU];
    logic       busyS[NU];
    logic       doneS[NU];

    int checks   = 0;
    int failures = 0;

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rstN(rstN), .txValid(vld[0]), .txIn(din[0][7:0]),
        .txReady(rdyS[0]), .tx(txS[0]), .busy(busyS[0]), .txDone(doneS[0]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rstN(rstN), .txValid(vld[1]), .txIn(din[1][7:0]),
        .txReady(rdyS[1]), .tx(txS[1]), .busy(busyS[1]), .txDone(doneS[1]));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rstN(rstN), .txValid(vld[2]), .txIn(din[2][7:0]),
        .txReady(rdyS[2]), .tx(txS[2]), .busy(busyS[2]), .txDone(doneS[2]));
    uart_tx_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rstN(rstN), .txValid(vld[3]), .txIn(din[3][4:0]),
        .txReady(rdyS[3]), .tx(txS[3]), .busy(busyS[3]), .txDone(doneS[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for each bit period of one frame, from the frame format rules.
    task automatic buildFrame(input int u, input logic [8:0] data, output bit q[$]);
        bit parOn;
        int ones;
        q = {};
`ifdef UART_TX_PARITY_EN
        parOn = (CFG_PAR[u] != 0);
`else
        parOn = 1'b0;
`endif
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < CFG_DB[u]; i++) begin
            q.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (parOn) q.push_back((CFG_PAR[u] == 2) ? (ones % 2 == 1) : (ones % 2 == 0));
        for (int i = 0; i < CFG_SB[u]; i++) q.push_back(1'b1);
    endtask

    // Called at a negedge with the DUT idle; optionally chains the next character with txValid held.
    task automatic sendFrame(input int u, input logic [8:0] data, input bit chain, input logic [8:0] nextData);
        bit   q[$];
        int   n, pj, ctlBad;
        logic obs;
        buildFrame(u, data, q);
        n = q.size() * DIV;
        vld[u] = 1'b1;
        din[u] = data;
        chk($sformatf("u%0d readyPre", u), rdyS[u], 1);
        @(posedge clk);
        pj = $urandom_range(n - 5, 5);
        ctlBad = 0;
        obs = q[0];
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j == 0) begin
                vld[u] = 1'b0;
                din[u] = 9'($urandom);
            end
            if (j == pj) begin
                vld[u] = 1'b1;
                din[u] = 9'($urandom);
            end
            if (j == pj + 1) vld[u] = 1'b0;
            if (chain && j == n - 1) begin
                vld[u] = 1'b1;
                din[u] = nextData;
            end
            if (j % DIV == 0) obs = q[j / DIV];
            if (txS[u] !== q[j / DIV]) obs = txS[u];
            if (busyS[u] !== 1'b1 || rdyS[u] !== 1'b0 || doneS[u] !== 1'b0) ctlBad++;
            if (j % DIV == DIV - 1)
                chk($sformatf("u%0d d%0h bit%0d", u, data, j / DIV), obs, q[j / DIV]);
        end
        chk($sformatf("u%0d ctlDuringFrame", u), ctlBad, 0);
        @(negedge clk);
        chk($sformatf("u%0d txDone", u), doneS[u], 1);
        chk($sformatf("u%0d busyAtDone", u), busyS[u], 0);
        chk($sformatf("u%0d readyAtDone", u), rdyS[u], 1);
        chk($sformatf("u%0d txAtDone", u), txS[u], 1);
        if (!chain) begin
            @(negedge clk);
            chk($sformatf("u%0d txDoneOff", u), doneS[u], 0);
            chk($sformatf("u%0d idleTx", u), txS[u], 1);
        end
    endtask

    initial begin
        logic [8:0] d, nd, dat;
        bit         c;
        int         bad;
        rstN = 1'b0;
        for (int u = 0; u < NU; u++) begin
            vld[u] = 1'b0;
            din[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk($sformatf("u%0d rstTx", u), txS[u], 1);
            chk($sformatf("u%0d rstBusy", u), busyS[u], 0);
            chk($sformatf("u%0d rstDone", u), doneS[u], 0);
            chk($sformatf("u%0d rstReady", u), rdyS[u], 1);
        end
        rstN = 1'b1;
        @(negedge clk);

        sendFrame(0, 9'h0A5, 1'b0, 9'h000);
        sendFrame(1, 9'h007, 1'b0, 9'h000);
        sendFrame(2, 9'h007, 1'b0, 9'h000);
        sendFrame(3, 9'h01F, 1'b0, 9'h000);
        sendFrame(0, 9'h055, 1'b1, 9'h0AA);
        sendFrame(0, 9'h0AA, 1'b0, 9'h000);

        // Abort a frame with reset at cycle 45, then confirm clean recovery.
        dat = 9'($urandom);
        vld[0] = 1'b1;
        din[0] = dat;
        @(posedge clk);
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (j == 0) vld[0] = 1'b0;
        end
        chk("abort preTx", txS[0], dat[3]);
        rstN = 1'b0;
        #1;
        chk("abort tx", txS[0], 1);
        chk("abort busy", busyS[0], 0);
        chk("abort ready", rdyS[0], 1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (doneS[0] !== 1'b0) bad++;
        end
        rstN = 1'b1;
        repeat (DIV * 2) begin
            @(negedge clk);
            if (doneS[0] !== 1'b0 || txS[0] !== 1'b1 || busyS[0] !== 1'b0) bad++;
        end
        chk("abort noResume", bad, 0);
        sendFrame(0, 9'($urandom), 1'b0, 9'h000);

        for (int u = 0; u < NU; u++) begin
            d = 9'($urandom);
            for (int k = 0; k < 6; k++) begin
                c  = (k < 5) && ($urandom_range(1, 0) == 1);
                nd = 9'($urandom);
                sendFrame(u, d, c, nd);
                d = c ? nd : 9'($urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
